// File: rtl/seq_mult_32_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master side (execute stage / testbench) drives the request and operands,
// the slave side (seq_mult_32) returns status and the product.
interface seq_mult_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic             ovf;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, prod_hi, prod_lo, ovf
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, prod_hi, prod_lo, ovf
  );
endinterface

// File: rtl/seq_mult_32.sv
// Multi-cycle shift-add multiplier for the ALU MULT slot.
// Operands are latched as magnitudes on START, WIDTH add/shift iterations run
// in RUN, and FIX applies the sign, writes the product and computes overflow.
// Latency from the START edge to DONE is fixed at WIDTH+1 cycles.
module seq_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_32_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]     mplr_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 neg_r;
  logic                 signed_r;

  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     prod_hi_r;
  logic [WIDTH-1:0]     prod_lo_r;
  logic                 ovf_r;

  logic                 busy_nxt_s;
  logic                 done_nxt_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   prod_raw_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic                 ovf_fix_s;
  logic                 last_iter_s;

  // Magnitude of an operand; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic use_sign);
    logic [WIDTH-1:0] m;
    if (use_sign && v[WIDTH-1]) begin
      m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: IDLE waits for START, RUN lasts WIDTH edges, FIX one edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered BUSY and DONE flags.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN:  busy_nxt_s = 1'b1;
      ST_FIX:  busy_nxt_s = 1'b1;
      default: busy_nxt_s = 1'b0;
    endcase
    if (state_r == ST_FIX) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // Add step, sign fix-up and overflow for the current datapath contents.
  always_comb begin
    if (mplr_r[0]) begin
      sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r};
    end
    prod_raw_s = {acc_r, mplr_r};
    if (neg_r) begin
      prod_fix_s = ~prod_raw_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      prod_fix_s = prod_raw_s;
    end
    if (signed_r) begin
      ovf_fix_s = (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix_s[WIDTH-1]}});
    end else begin
      ovf_fix_s = (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end
  end

  // Iteration datapath: operand latch in IDLE, add-and-shift in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {WIDTH{1'b0}};
      mplr_r   <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      neg_r    <= 1'b0;
      signed_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            acc_r    <= {WIDTH{1'b0}};
            mplr_r   <= magnitude(bus.b, bus.is_signed);
            mcand_r  <= magnitude(bus.a, bus.is_signed);
            cnt_r    <= {CNT_W{1'b0}};
            neg_r    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            signed_r <= bus.is_signed;
          end
        end
        ST_RUN: begin
          // {carry, acc, mplr} shifted right by one.
          acc_r  <= sum_s[WIDTH:1];
          mplr_r <= {sum_s[0], mplr_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result registers: written only on the FIX edge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_hi_r <= {WIDTH{1'b0}};
      prod_lo_r <= {WIDTH{1'b0}};
      ovf_r     <= 1'b0;
    end else if (state_r == ST_FIX) begin
      prod_hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
      prod_lo_r <= prod_fix_s[WIDTH-1:0];
      ovf_r     <= ovf_fix_s;
    end
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.prod_hi = prod_hi_r;
  assign bus.prod_lo = prod_lo_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_seq_mult_32.sv
// Self-checking bench for seq_mult_32: directed corner cases, randomized
// operands against an arithmetic reference model, handshake and reset scenarios.
module tb_seq_mult_32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  seq_mult_32_if #(.WIDTH(32)) bus ();

  seq_mult_32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference product straight from integer arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] hi, output logic [31:0] lo, output logic ovf);
    longint sp;
    logic [63:0] up;
    if (s) begin
      sp  = longint'($signed(a)) * longint'($signed(b));
      up  = 64'(sp);
      ovf = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    end else begin
      up  = {32'h0, a} * {32'h0, b};
      ovf = (up[63:32] != 32'h0);
    end
    hi = up[63:32];
    lo = up[31:0];
  endtask

  // Drive a one-cycle START; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_signed = s;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges until DONE is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = 32'h0; bus.b = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.ovf, bus.prod_hi, bus.prod_lo} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b hi=%h lo=%h, want all 0",
               bus.busy, bus.done, bus.ovf, bus.prod_hi, bus.prod_lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_unsigned_directed();
    int cyc;
    int bad;
    // 3 x 5 with a full BUSY/DONE trace.
    launch(32'd3, 32'd5, 1'b0);
    bad = 0;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_trace: %0d cycles with wrong busy/done, want 0", bad);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.prod_lo !== 32'h0000000F ||
        bus.prod_hi !== 32'h0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_3x5: got done=%b busy=%b hi=%h lo=%h ovf=%b, want 1 0 0 f 0",
               bus.done, bus.busy, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b one cycle later, want 0", bus.done);
    end
    // All-ones squared.
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_hi !== 32'hFFFFFFFE || bus.prod_lo !== 32'h00000001 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ffff: got lat=%0d hi=%h lo=%h ovf=%b, want 33 fffffffe 00000001 1",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
  endtask

  task automatic test_signed_directed();
    int cyc;
    launch(32'hFFFFFFF9, 32'h00000003, 1'b1);
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_hi !== 32'hFFFFFFFF || bus.prod_lo !== 32'hFFFFFFEB || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_m7x3: got lat=%0d hi=%h lo=%h ovf=%b, want 33 ffffffff ffffffeb 0",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
    launch(32'h80000000, 32'h80000000, 1'b1);
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_hi !== 32'h40000000 || bus.prod_lo !== 32'h0 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_min_sq: got lat=%0d hi=%h lo=%h ovf=%b, want 33 40000000 0 1",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
    // Zero times a negative: negative zero must come out as plain zero.
    launch(32'h0, 32'hFFFFFFFB, 1'b1);
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_hi !== 32'h0 || bus.prod_lo !== 32'h0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_zero: got lat=%0d hi=%h lo=%h ovf=%b, want 33 0 0 0",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ehi, elo;
    logic s, eovf;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 8)
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = a >> 20;
        3: b = b >> 24;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, ehi, elo, eovf);
      launch(a, b, s);
      // Scribble the operand inputs during RUN; they must not matter.
      bus.a = $urandom; bus.b = $urandom; bus.is_signed = ~s;
      wait_done(cyc);
      n_vec++;
      if (cyc != 33 || bus.prod_hi !== ehi || bus.prod_lo !== elo || bus.ovf !== eovf) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h s=%b: got lat=%0d hi=%h lo=%h ovf=%b, want 33 %h %h %b",
                 i, a, b, s, cyc, bus.prod_hi, bus.prod_lo, bus.ovf, ehi, elo, eovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ehi, elo;
    logic eovf;
    int cyc;
    int pulses;
    model(32'h00012345, 32'h00006789, 1'b0, ehi, elo, eovf);
    launch(32'h00012345, 32'h00006789, 1'b0);
    cyc = 0;
    pulses = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5 || cyc == 20) begin
        bus.start = 1'b1; bus.a = 32'hDEAD0000 + 32'(cyc); bus.b = 32'h00BEEF00;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) pulses++;
    end
    n_vec++;
    if (cyc != 33 || pulses != 1 || bus.prod_hi !== ehi || bus.prod_lo !== elo || bus.ovf !== eovf) begin
      n_fail++;
      $display("FAIL start_busy: got lat=%0d pulses=%0d hi=%h lo=%h, want 33 1 %h %h",
               cyc, pulses, bus.prod_hi, bus.prod_lo, ehi, elo);
    end
    // START presented in the DONE cycle is accepted.
    bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2; bus.is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.prod_lo !== elo) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b lo=%h, want 0 1 %h",
               bus.done, bus.busy, bus.prod_lo, elo);
    end
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_lo !== 32'd4 || bus.prod_hi !== 32'h0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got lat=%0d hi=%h lo=%h ovf=%b, want 33 0 4 0",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    launch(32'h1234, 32'h10, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.ovf, bus.prod_hi, bus.prod_lo} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b ovf=%b hi=%h lo=%h, want all 0",
               bus.busy, bus.done, bus.ovf, bus.prod_hi, bus.prod_lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.prod_lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b done=%b lo=%h, want 0 0 0",
               bus.busy, bus.done, bus.prod_lo);
    end
    launch(32'd6, 32'd7, 1'b0);
    wait_done(cyc);
    n_vec++;
    if (cyc != 33 || bus.prod_lo !== 32'd42 || bus.prod_hi !== 32'h0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d hi=%h lo=%h ovf=%b, want 33 0 2a 0",
               cyc, bus.prod_hi, bus.prod_lo, bus.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_directed();
    test_signed_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
